seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 104 ++++++++++
 tb/tb_seven_segment_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed 4-digit seven-segment driver; outputs registered, one clock from inputs to pins.
// No backpressure: the scan free-runs and input changes take effect on the next edge.
module seven_segment_scanner #(
  parameter int PRESCALE = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_en,
  input  logic [3:0] dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       scan_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          wrap;
  logic [3:0]    nib;
  logic          sel_en;
  logic          sel_dp;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  assign wrap = (cnt == CNT_LAST);

  always_comb begin
    nib    = digit_0;
    sel_en = digit_en[idx];
    sel_dp = dp_in[idx];
    case (idx)
      2'd0: nib = digit_0;
      2'd1: nib = digit_1;
      2'd2: nib = digit_2;
      2'd3: nib = digit_3;
      default: nib = digit_0;
    endcase
  end

  // Active-low gfedcba glyphs for hex 0..F
  always_comb begin
    seg_dec = 7'b1111111;
    case (nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (sel_en) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = seg_dec;
      dp_nxt  = ~sel_dp;
    end
  end

  // Anodes come from a single registered idx, so at most one is ever low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= 2'd0;
      scan_tick <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      scan_tick <= wrap;
      cnt       <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized and directed bench for seven_segment_scanner at PRESCALE=4.
module tb_seven_segment_scanner;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_0 = 4'h0, digit_1 = 4'h0, digit_2 = 4'h0, digit_3 = 4'h0;
  logic [3:0] digit_en = 4'b1111;
  logic [3:0] dp_in = 4'b0000;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       scan_tick;

  int errors = 0;
  int checks = 0;
  int k = -1;  // index of the most recent edge since reset release

  seven_segment_scanner #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_en(digit_en), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Edge e after release shows slot (e / P) mod 4 using inputs present at that edge;
  // the tick is seen after the last edge of each slot.
  function automatic logic [12:0] exp_vec(int e);
    int s;
    logic [3:0] n;
    logic [3:0] a;
    logic [6:0] sg;
    logic d;
    s = (e / P) % 4;
    n = (s == 0) ? digit_0 : (s == 1) ? digit_1 : (s == 2) ? digit_2 : digit_3;
    a = 4'b1111; sg = 7'b1111111; d = 1'b1;
    if (digit_en[s]) begin
      a = an_tbl[s]; sg = seg_tbl[n]; d = ~dp_in[s];
    end
    return {a, sg, d, (e % P) == (P - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    k = -1;
  endtask

  task automatic test_reset();
    digit_en = 4'b1111; digit_0 = 4'h8; digit_1 = 4'h8; digit_2 = 4'h8; digit_3 = 4'h8;
    do_reset();
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++;
    if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
    checks++;
    if (scan_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", scan_tick); end
    @(negedge clk);
    reset = 1'b0;
    k = -1;
    tick();
    checks++;
    if ({an, seg, dp, scan_tick} !== exp_vec(k))
      begin errors++; $display("FAIL first_edge got %b exp %b", {an, seg, dp, scan_tick}, exp_vec(k)); end
  endtask

  task automatic test_digits();
    digit_3 = 4'hF; digit_2 = 4'h8; digit_1 = 4'h1; digit_0 = 4'h0;
    digit_en = 4'b1111; dp_in = 4'b0000;
    do_reset();
    repeat (4 * P + P) begin
      tick();
      checks++;
      if ({an, seg, dp, scan_tick} !== exp_vec(k))
        begin errors++; $display("FAIL digits k=%0d got %b exp %b", k, {an, seg, dp, scan_tick}, exp_vec(k)); end
    end
  endtask

  task automatic test_scan_tick();
    int cnt_ticks = 0;
    int last = -100;
    int bad_gap = 0;
    do_reset();
    repeat (32) begin
      tick();
      if (scan_tick === 1'b1) begin
        if (last >= 0 && k - last != P) bad_gap++;
        last = k;
        cnt_ticks++;
      end
    end
    checks++;
    if (cnt_ticks != 8) begin errors++; $display("FAIL tick_count got %0d exp 8", cnt_ticks); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL tick_spacing bad gaps %0d exp 0", bad_gap); end
  endtask

  task automatic test_enable();
    digit_en = 4'b0101;
    digit_0 = 4'($urandom); digit_1 = 4'($urandom); digit_2 = 4'($urandom); digit_3 = 4'($urandom);
    dp_in = 4'($urandom);
    do_reset();
    repeat (4 * P) begin
      tick();
      checks++;
      if ({an, seg, dp, scan_tick} !== exp_vec(k))
        begin errors++; $display("FAIL enable k=%0d got %b exp %b", k, {an, seg, dp, scan_tick}, exp_vec(k)); end
    end
  endtask

  task automatic test_midslot();
    digit_en = 4'b1111; digit_0 = 4'h0; dp_in = 4'b0001;
    do_reset();
    repeat (2) tick();
    checks++;
    if (seg !== 7'b1000000) begin errors++; $display("FAIL midslot_before got %b exp 1000000", seg); end
    digit_0 = 4'hA;
    repeat (2) begin
      tick();
      checks++;
      if (seg !== 7'b0001000 || an !== 4'b1110)
        begin errors++; $display("FAIL midslot_after k=%0d got %b/%b exp 0001000/1110", k, seg, an); end
    end
    repeat (4 * P - 4) begin
      tick();
      checks++;
      if (dp !== (((k / P) % 4) == 0 ? 1'b0 : 1'b1))
        begin errors++; $display("FAIL midslot_dp k=%0d got %b", k, dp); end
    end
  endtask

  task automatic test_sweep();
    digit_en = 4'b0001; dp_in = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      digit_0 = 4'(v);
      do_reset();
      tick();
      checks++;
      if (seg !== seg_tbl[v] || an !== 4'b1110)
        begin errors++; $display("FAIL sweep v=%0d got %b exp %b", v, seg, seg_tbl[v]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      digit_0 = 4'($urandom); digit_1 = 4'($urandom); digit_2 = 4'($urandom); digit_3 = 4'($urandom);
      digit_en = 4'($urandom); dp_in = 4'($urandom);
      tick();
      checks++;
      if ({an, seg, dp, scan_tick} !== exp_vec(k) || $countones(~an) > 1)
        begin errors++; $display("FAIL random k=%0d got %b exp %b", k, {an, seg, dp, scan_tick}, exp_vec(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_scan_tick();
    test_enable();
    test_midslot();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
